// File: rtl/ssemi_decim_integrate_dump_pkg.sv
// Shared defaults and parameter helpers for the decimation chain.
package ssemi_decim_integrate_dump_pkg;

  localparam int unsigned SSEMI_DECIM_DATA_WIDTH     = 16;
  localparam int unsigned SSEMI_DECIM_CNT_WIDTH      = 8;
  localparam int unsigned SSEMI_DECIM_FIFO_DEPTH     = 4;
  localparam int unsigned SSEMI_DECIM_FIFO_DEPTH_MAX = 16;

  // Legal FIFO depth: power of two between 2 and the supported maximum.
  function automatic bit fifo_depth_ok(input int unsigned depth);
    return (depth >= 2) && (depth <= SSEMI_DECIM_FIFO_DEPTH_MAX) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/ssemi_sync_fifo.sv
// Small first-word-fall-through FIFO with async reset and sync clear.
module ssemi_sync_fifo
  import ssemi_decim_integrate_dump_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
    $error("ssemi_sync_fifo: DEPTH must be a power of two in 2..16");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             do_pop;
  logic             do_push;

  assign o_empty = (level == '0);
  assign o_full  = (level == (AW+1)'(DEPTH));
  assign o_level = level;
  assign o_head  = o_empty ? '0 : mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  // Pointer and level bookkeeping; clear wins over push/pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: unread entries are masked by o_empty.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_clear) mem[wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/ssemi_decim_integrate_dump.sv
// Integrate-and-dump first decimation stage feeding a FWFT dump FIFO.
module ssemi_decim_integrate_dump
  import ssemi_decim_integrate_dump_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SSEMI_DECIM_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = SSEMI_DECIM_CNT_WIDTH,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + CNT_WIDTH,
  parameter int unsigned FIFO_DEPTH = SSEMI_DECIM_FIFO_DEPTH
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_enable,
  input  logic                           i_sync_reset,
  input  logic signed [DATA_WIDTH-1:0]   i_sample,
  input  logic                           i_sample_valid,
  input  logic                           i_dump_strobe,
  input  logic                           i_clear_flags,
  output logic signed [ACC_WIDTH-1:0]    o_data,
  output logic [CNT_WIDTH-1:0]           o_count,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [$clog2(FIFO_DEPTH):0]    o_fifo_level,
  output logic                           o_overflow,
  output logic                           o_cnt_sat
);

  localparam int unsigned WORD_W = ACC_WIDTH + CNT_WIDTH;

  logic signed [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]        count;
  logic signed [ACC_WIDTH-1:0] sample_ext;
  logic signed [ACC_WIDTH-1:0] sum_in;
  logic [CNT_WIDTH-1:0]        cnt_in;
  logic                        cnt_full;
  logic                        accum;
  logic                        dump;
  logic                        sat_evt;
  logic                        ovf_evt;
  logic                        pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [WORD_W-1:0]           head;

  // Sum/count including this cycle's sample; used by both accumulate and dump.
  assign sample_ext = ACC_WIDTH'(signed'(i_sample));
  assign sum_in     = i_sample_valid ? acc + sample_ext : acc;
  assign cnt_full   = &count;
  assign cnt_in     = (i_sample_valid && !cnt_full) ? count + 1'b1 : count;

  assign accum   = i_enable && i_sample_valid && !i_dump_strobe;
  assign dump    = i_enable && i_dump_strobe;
  assign sat_evt = i_enable && i_sample_valid && cnt_full;
  assign pop     = o_valid && i_ready;
  assign ovf_evt = dump && fifo_full && !pop;

  // Running integrator; cleared on dump even if the FIFO drops the word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc   <= '0;
      count <= '0;
    end else if (i_sync_reset || !i_enable || dump) begin
      acc   <= '0;
      count <= '0;
    end else if (accum) begin
      acc   <= sum_in;
      count <= cnt_in;
    end
  end

  // Sticky flags; a same-cycle event beats the clear request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
      o_cnt_sat  <= 1'b0;
    end else if (i_sync_reset) begin
      o_overflow <= 1'b0;
      o_cnt_sat  <= 1'b0;
    end else begin
      o_overflow <= ovf_evt || (o_overflow && !i_clear_flags);
      o_cnt_sat  <= sat_evt || (o_cnt_sat && !i_clear_flags);
    end
  end

  ssemi_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_sync_reset),
    .i_push      (dump),
    .i_push_data ({sum_in, cnt_in}),
    .i_pop       (pop),
    .o_head      (head),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_level     (o_fifo_level)
  );

  assign o_valid = !fifo_empty;
  assign o_data  = head[WORD_W-1 -: ACC_WIDTH];
  assign o_count = head[CNT_WIDTH-1:0];

endmodule

// File: tb/tb_ssemi_decim_integrate_dump.sv
// Directed bench for the integrate/dump stage with hand-computed expectations.
module tb_ssemi_decim_integrate_dump;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               enable2;
  logic               sync_reset;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               dump_strobe;
  logic               clear_flags;
  logic               ready;

  logic signed [23:0] data;
  logic [7:0]         count;
  logic               valid;
  logic [2:0]         level;
  logic               overflow;
  logic               cnt_sat;

  logic signed [17:0] data2;
  logic [1:0]         count2;
  logic               valid2;
  logic [2:0]         level2;
  logic               overflow2;
  logic               cnt_sat2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ssemi_decim_integrate_dump #(
    .DATA_WIDTH (16),
    .CNT_WIDTH  (8),
    .ACC_WIDTH  (24),
    .FIFO_DEPTH (4)
  ) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_sync_reset   (sync_reset),
    .i_sample       (sample),
    .i_sample_valid (sample_valid),
    .i_dump_strobe  (dump_strobe),
    .i_clear_flags  (clear_flags),
    .o_data         (data),
    .o_count        (count),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_fifo_level   (level),
    .o_overflow     (overflow),
    .o_cnt_sat      (cnt_sat)
  );

  ssemi_decim_integrate_dump #(
    .DATA_WIDTH (16),
    .CNT_WIDTH  (2),
    .ACC_WIDTH  (18),
    .FIFO_DEPTH (4)
  ) u_dut_sat (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable2),
    .i_sync_reset   (sync_reset),
    .i_sample       (sample),
    .i_sample_valid (sample_valid),
    .i_dump_strobe  (dump_strobe),
    .i_clear_flags  (clear_flags),
    .o_data         (data2),
    .o_count        (count2),
    .o_valid        (valid2),
    .i_ready        (ready),
    .o_fifo_level   (level2),
    .o_overflow     (overflow2),
    .o_cnt_sat      (cnt_sat2)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Apply one cycle of stimulus, then land 1 ns after the active edge.
  task automatic cyc(input int s, input bit v, input bit st);
    sample       = 16'(s);
    sample_valid = v;
    dump_strobe  = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; enable2 = 1'b0; sync_reset = 1'b0;
    sample = '0; sample_valid = 1'b0; dump_strobe = 1'b0;
    clear_flags = 1'b0; ready = 1'b1;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_count", count, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sat", cnt_sat, 0);
    #1 rst = 1'b0;

    // Ramp with ratio-4 strobes
    cyc(1, 1, 0); cyc(2, 1, 0); cyc(3, 1, 0);
    chk("ramp_not_yet", valid, 0);
    cyc(4, 1, 1);
    chk("ramp1_valid", valid, 1);
    chk("ramp1_data", data, 10);
    chk("ramp1_count", count, 4);
    chk("ramp1_level", level, 1);
    cyc(5, 1, 0);
    chk("ramp1_popped", valid, 0);
    cyc(6, 1, 0); cyc(7, 1, 0); cyc(8, 1, 1);
    chk("ramp2_data", data, 26);
    chk("ramp2_count", count, 4);

    // Empty interval dump (26 pops on the same edge)
    cyc(0, 0, 1);
    chk("empty_valid", valid, 1);
    chk("empty_data", data, 0);
    chk("empty_count", count, 0);
    chk("empty_level", level, 1);
    cyc(0, 0, 0);
    chk("empty_drained", valid, 0);

    // Overflow: five dumps into a depth-4 FIFO with no consumer
    ready = 1'b0;
    for (int k = 1; k <= 4; k++) cyc(k, 1, 1);
    chk("fill_level", level, 4);
    chk("fill_no_ovf", overflow, 0);
    cyc(5, 1, 1);
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    ready = 1'b1;
    #1;
    chk("drain_data1", data, 1);
    chk("drain_count1", count, 1);
    for (int k = 2; k <= 4; k++) begin
      cyc(0, 0, 0);
      chk($sformatf("drain_data%0d", k), data, k);
    end
    cyc(0, 0, 0);
    chk("drain_fifth_absent", valid, 0);
    chk("ovf_sticky", overflow, 1);
    clear_flags = 1'b1;
    cyc(0, 0, 0);
    clear_flags = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Negative full-scale samples
    ready = 1'b0;
    cyc(-32768, 1, 0); cyc(-32768, 1, 0); cyc(-32768, 1, 0);
    cyc(0, 0, 1);
    chk("neg_data", data, -98304);
    chk("neg_count", count, 3);
    ready = 1'b1;
    cyc(0, 0, 0);
    chk("neg_popped", valid, 0);

    // Counter saturation on the CNT_WIDTH=2 instance
    ready = 1'b0; enable2 = 1'b1;
    for (int k = 0; k < 5; k++) cyc(1, 1, 0);
    chk("sat_flag_early", cnt_sat2, 1);
    cyc(0, 0, 1);
    chk("sat_count", count2, 3);
    chk("sat_data", data2, 5);
    chk("sat_flag", cnt_sat2, 1);
    chk("nosat_count", count, 5);
    chk("nosat_flag", cnt_sat, 0);
    ready = 1'b1;
    cyc(0, 0, 0);
    enable2 = 1'b0;
    chk("sat_popped", valid, 0);

    // Full FIFO with simultaneous pop and push
    ready = 1'b0;
    for (int k = 11; k <= 14; k++) cyc(k, 1, 1);
    chk("fullpp_pre_level", level, 4);
    ready = 1'b1;
    cyc(15, 1, 1);
    chk("fullpp_level", level, 4);
    chk("fullpp_no_ovf", overflow, 0);
    chk("fullpp_head", data, 12);
    cyc(0, 0, 0);
    chk("fullpp_d13", data, 13);
    cyc(0, 0, 0);
    chk("fullpp_d14", data, 14);
    cyc(0, 0, 0);
    chk("fullpp_tail", data, 15);
    chk("fullpp_tail_cnt", count, 1);
    cyc(0, 0, 0);
    chk("fullpp_drained", valid, 0);

    // Asynchronous reset mid-interval with words queued
    ready = 1'b0;
    cyc(1, 1, 1); cyc(2, 1, 1);
    chk("arst_pre_level", level, 2);
    cyc(3, 1, 0); cyc(3, 1, 0); cyc(3, 1, 0);
    rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_data", data, 0);
    chk("arst_count", count, 0);
    chk("arst_level", level, 0);
    #1 rst = 1'b0;
    cyc(7, 1, 0); cyc(7, 1, 1);
    chk("post_rst_data", data, 14);
    chk("post_rst_count", count, 2);

    // Synchronous reset beats a same-cycle strobe
    sync_reset = 1'b1;
    cyc(9, 1, 1);
    sync_reset = 1'b0;
    chk("sync_level", level, 0);
    chk("sync_valid", valid, 0);
    chk("sync_data", data, 0);
    cyc(0, 0, 1);
    chk("post_sync_data", data, 0);
    chk("post_sync_count", count, 0);
    chk("post_sync_level", level, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
